// File: rtl/branch_predict_unit_if.sv
// Decode/fetch-side signal bundle for the branch predictor.
// The master side is the pipeline; the slave side is the predictor.
interface branch_predict_unit_if;
   logic [31:0] pcF;
   logic        predTakenF;
   logic        validD;
   logic        stallD;
   logic [31:0] pcD;
   logic [31:0] instrD;
   logic [31:0] a;
   logic [31:0] b;
   logic        predTakenD;
   logic        isBranchD;
   logic        takenD;
   logic        mispredictD;
   logic        isSaveReg31;
   logic        isSaveReg;
   logic        isJumpToReg;
   logic [31:0] branchCnt;
   logic [31:0] missCnt;

   modport master (
      output pcF, validD, stallD, pcD, instrD, a, b, predTakenD,
      input  predTakenF, isBranchD, takenD, mispredictD, isSaveReg31, isSaveReg, isJumpToReg,
             branchCnt, missCnt
   );

   modport slave (
      input  pcF, validD, stallD, pcD, instrD, a, b, predTakenD,
      output predTakenF, isBranchD, takenD, mispredictD, isSaveReg31, isSaveReg, isJumpToReg,
             branchCnt, missCnt
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: saturating-counter table read in fetch, resolved and
// trained in decode, with MIPS branch/jump decode and hit/miss statistics.
module branch_predict_unit #(
   parameter int unsigned BHT_DEPTH  = 64,
   parameter int unsigned CNT_W      = 2,
   parameter bit          PREDICT_EN = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   branch_predict_unit_if.slave bus
);
   localparam int unsigned IDXW = $clog2(BHT_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

   logic [CNT_W-1:0] r_table [BHT_DEPTH];
   logic [31:0]      r_branch_cnt;
   logic [31:0]      r_miss_cnt;

   logic [5:0]      w_op;
   logic [4:0]      w_rt;
   logic [5:0]      w_funct;
   logic            w_br_op;
   logic            w_cond;
   logic            w_is_branch;
   logic            w_taken;
   logic            w_mispredict;
   logic            w_special;
   logic            w_save31;
   logic            w_update;
   logic [IDXW-1:0] w_idx_f;
   logic [IDXW-1:0] w_idx_d;
   logic [CNT_W-1:0] w_cnt_cur;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic            w_unused;

   assign w_op    = bus.instrD[31:26];
   assign w_rt    = bus.instrD[20:16];
   assign w_funct = bus.instrD[5:0];
   assign w_idx_f = bus.pcF[IDXW+1:2];
   assign w_idx_d = bus.pcD[IDXW+1:2];

   always_comb begin
      w_br_op = 1'b0;
      w_cond  = 1'b0;
      case (w_op)
         6'b000100: begin w_br_op = 1'b1; w_cond = (bus.a == bus.b); end
         6'b000101: begin w_br_op = 1'b1; w_cond = (bus.a != bus.b); end
         6'b000110: begin w_br_op = 1'b1; w_cond = bus.a[31] | (bus.a == 32'd0); end
         6'b000111: begin w_br_op = 1'b1; w_cond = ~bus.a[31] & (bus.a != 32'd0); end
         // REGIMM: rt[0] selects BGEZ-family vs BLTZ-family
         6'b000001: begin w_br_op = 1'b1; w_cond = w_rt[0] ? ~bus.a[31] : bus.a[31]; end
         default:   begin w_br_op = 1'b0; w_cond = 1'b0; end
      endcase
   end

   assign w_is_branch  = bus.validD & w_br_op;
   assign w_taken      = w_is_branch & w_cond;
   assign w_mispredict = w_is_branch & (w_taken != bus.predTakenD);
   assign w_special    = (w_op == 6'b000000);
   assign w_save31     = bus.validD & ((w_op == 6'b000011) | ((w_op == 6'b000001) & w_rt[4]));
   assign w_update     = w_is_branch & ~bus.stallD;

   assign bus.isBranchD   = w_is_branch;
   assign bus.takenD      = w_taken;
   assign bus.mispredictD = w_mispredict;
   assign bus.isSaveReg31 = w_save31;
   assign bus.isSaveReg   = w_save31 | (bus.validD & w_special & (w_funct == 6'b001001));
   assign bus.isJumpToReg = bus.validD & w_special &
                            ((w_funct == 6'b001000) | (w_funct == 6'b001001));
   assign bus.predTakenF  = PREDICT_EN ? r_table[w_idx_f][CNT_W-1] : 1'b0;
   assign bus.branchCnt   = r_branch_cnt;
   assign bus.missCnt     = r_miss_cnt;

   assign w_cnt_cur = r_table[w_idx_d];

   always_comb begin
      w_cnt_nxt = w_cnt_cur;
      if (w_taken && (w_cnt_cur != CNT_MAX)) begin
         w_cnt_nxt = w_cnt_cur + 1'b1;
      end else if (!w_taken && (w_cnt_cur != '0)) begin
         w_cnt_nxt = w_cnt_cur - 1'b1;
      end
   end

   // Table stays frozen at its reset value when dynamic prediction is disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            r_table[i] <= CNT_INIT;
         end
      end else if (w_update && PREDICT_EN) begin
         r_table[w_idx_d] <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_branch_cnt <= '0;
         r_miss_cnt   <= '0;
      end else if (w_update) begin
         if (r_branch_cnt != 32'hFFFF_FFFF) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
         end
         if (w_mispredict && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign w_unused = ^{bus.instrD[25:21], bus.instrD[15:6], bus.pcF[31:IDXW+2], bus.pcF[1:0],
                       bus.pcD[31:IDXW+2], bus.pcD[1:0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: decode vector table, directed corner sequences and
// randomized traffic against a behavioural model, on PREDICT_EN=1 and PREDICT_EN=0 copies.
module tb_branch_predict_unit;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned CW    = 2;
   localparam int          CMAX  = (1 << CW) - 1;
   localparam int          CINIT = (1 << (CW - 1)) - 1;
   localparam int          CHALF = 1 << (CW - 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predict_unit_if bus0 ();
   branch_predict_unit_if bus1 ();

   branch_predict_unit #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .PREDICT_EN(1'b1)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );
   branch_predict_unit #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .PREDICT_EN(1'b0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct packed {
      logic br;
      logic tk;
      logic s31;
      logic s;
      logic jr;
   } dec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic        valid;
      logic        predd;
      logic        br;
      logic        tk;
      logic        mis;
      logic        s31;
      logic        s;
      logic        jr;
   } vec_t;

   int     n_checks = 0;
   int     n_errors = 0;
   int     m_tbl [DEPTH];
   longint m_bcnt;
   longint m_mcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [5:0] fn);
      return {op, 5'd0, rt, 10'd0, fn};
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic dec_t ref_decode(input logic [31:0] instr, input logic [31:0] a,
                                       input logic [31:0] b, input logic valid);
      dec_t   d  = '0;
      int     op = int'(instr[31:26]);
      int     rt = int'(instr[20:16]);
      int     fn = int'(instr[5:0]);
      longint sa = longint'($signed(a));
      if (!valid) return d;
      case (op)
         4: begin d.br = 1'b1; d.tk = (a == b); end
         5: begin d.br = 1'b1; d.tk = (a != b); end
         6: begin d.br = 1'b1; d.tk = (sa <= 0); end
         7: begin d.br = 1'b1; d.tk = (sa > 0); end
         1: begin
            d.br  = 1'b1;
            d.tk  = (rt % 2 == 1) ? (sa >= 0) : (sa < 0);
            d.s31 = (rt >= 16);
         end
         3: d.s31 = 1'b1;
         0: begin
            d.jr = (fn == 8) || (fn == 9);
            d.s  = (fn == 9);
         end
         default: ;
      endcase
      d.s = d.s | d.s31;
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = CINIT;
      m_bcnt = 0;
      m_mcnt = 0;
   endtask

   task automatic drive(input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] instr,
                        input logic [31:0] a, input logic [31:0] b, input logic valid,
                        input logic stall, input logic predd);
      bus0.pcF = pcf; bus0.pcD = pcd; bus0.instrD = instr; bus0.a = a; bus0.b = b;
      bus0.validD = valid; bus0.stallD = stall; bus0.predTakenD = predd;
      bus1.pcF = pcf; bus1.pcD = pcd; bus1.instrD = instr; bus1.a = a; bus1.b = b;
      bus1.validD = valid; bus1.stallD = stall; bus1.predTakenD = predd;
   endtask

   // One decode cycle: combinational checks before the edge, model update at the edge,
   // counter checks just after it.
   task automatic step(input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b, input logic valid,
                       input logic stall, input logic predd);
      dec_t d;
      logic mis;
      int   k;
      drive(pcf, pcd, instr, a, b, valid, stall, predd);
      #1;
      d   = ref_decode(instr, a, b, valid);
      mis = d.br && (d.tk != predd);
      chk("isBranchD0", bus0.isBranchD, d.br);
      chk("takenD0", bus0.takenD, d.tk);
      chk("mispredictD0", bus0.mispredictD, mis);
      chk("isSaveReg31_0", bus0.isSaveReg31, d.s31);
      chk("isSaveReg0", bus0.isSaveReg, d.s);
      chk("isJumpToReg0", bus0.isJumpToReg, d.jr);
      chk("mispredictD1", bus1.mispredictD, mis);
      chk("predTakenF0", bus0.predTakenF, m_tbl[idx_of(pcf)] >= CHALF);
      chk("predTakenF1", bus1.predTakenF, 1'b0);
      @(posedge clk);
      if (d.br && !stall) begin
         k = idx_of(pcd);
         if (d.tk) m_tbl[k] = (m_tbl[k] < CMAX) ? m_tbl[k] + 1 : CMAX;
         else      m_tbl[k] = (m_tbl[k] > 0) ? m_tbl[k] - 1 : 0;
         if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
         if (mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      end
      #1;
      chk("branchCnt0", bus0.branchCnt, m_bcnt[31:0]);
      chk("missCnt0", bus0.missCnt, m_mcnt[31:0]);
      chk("branchCnt1", bus1.branchCnt, m_bcnt[31:0]);
      chk("missCnt1", bus1.missCnt, m_mcnt[31:0]);
   endtask

   task automatic nop(input logic [31:0] pcf);
      step(pcf, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vec_t        vecs [18];
      logic [31:0] beq;
      logic [31:0] bne;
      longint      b0;
      logic [31:0] pcf, pcd, instr, a, b;
      int          kind;

      beq = enc(6'd4, 5'd0, 6'd0);
      bne = enc(6'd5, 5'd0, 6'd0);
      //          instr                      a             b      v  p  br tk mi 31 s  jr
      vecs[0]  = '{beq,                      32'd5,        32'd5, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[1]  = '{beq,                      32'd5,        32'd6, 1, 1, 1, 0, 1, 0, 0, 0};
      vecs[2]  = '{bne,                      32'd5,        32'd6, 1, 0, 1, 1, 1, 0, 0, 0};
      vecs[3]  = '{enc(6'd6, 5'd0, 6'd0),    32'd0,        32'd0, 1, 0, 1, 1, 1, 0, 0, 0};
      vecs[4]  = '{enc(6'd6, 5'd0, 6'd0),    32'd1,        32'd0, 1, 0, 1, 0, 0, 0, 0, 0};
      vecs[5]  = '{enc(6'd6, 5'd0, 6'd0),    32'h80000000, 32'd0, 1, 1, 1, 1, 0, 0, 0, 0};
      vecs[6]  = '{enc(6'd7, 5'd0, 6'd0),    32'd1,        32'd0, 1, 0, 1, 1, 1, 0, 0, 0};
      vecs[7]  = '{enc(6'd7, 5'd0, 6'd0),    32'd0,        32'd0, 1, 1, 1, 0, 1, 0, 0, 0};
      vecs[8]  = '{enc(6'd1, 5'd0, 6'd0),    32'hFFFFFFFF, 32'd0, 1, 0, 1, 1, 1, 0, 0, 0};
      vecs[9]  = '{enc(6'd1, 5'd1, 6'd0),    32'h80000000, 32'd0, 1, 0, 1, 0, 0, 0, 0, 0};
      vecs[10] = '{enc(6'd1, 5'd17, 6'd0),   32'd0,        32'd0, 1, 0, 1, 1, 1, 1, 1, 0};
      vecs[11] = '{enc(6'd1, 5'd16, 6'd0),   32'd5,        32'd0, 1, 0, 1, 0, 0, 1, 1, 0};
      vecs[12] = '{enc(6'd3, 5'd0, 6'd0),    32'd0,        32'd0, 1, 1, 0, 0, 0, 1, 1, 0};
      vecs[13] = '{enc(6'd0, 5'd0, 6'd8),    32'd0,        32'd0, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[14] = '{enc(6'd0, 5'd0, 6'd9),    32'd0,        32'd0, 1, 1, 0, 0, 0, 0, 1, 1};
      vecs[15] = '{beq,                      32'd5,        32'd5, 0, 1, 0, 0, 0, 0, 0, 0};
      vecs[16] = '{enc(6'd2, 5'd0, 6'd0),    32'd0,        32'd0, 1, 1, 0, 0, 0, 0, 0, 0};
      vecs[17] = '{enc(6'd0, 5'd0, 6'd32),   32'd0,        32'd0, 1, 0, 0, 0, 0, 0, 0, 0};

      // Reset
      drive(32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      model_reset();
      #12;
      chk("rst_branchCnt", bus0.branchCnt, 32'd0);
      chk("rst_missCnt", bus0.missCnt, 32'd0);
      chk("rst_predTakenF", bus0.predTakenF, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Decode table, held stalled so no state changes
      foreach (vecs[i]) begin
         step(32'h40, 32'h40, vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].valid, 1'b1,
              vecs[i].predd);
         chk($sformatf("vec%0d_isBranchD", i), bus0.isBranchD, vecs[i].br);
         chk($sformatf("vec%0d_takenD", i), bus0.takenD, vecs[i].tk);
         chk($sformatf("vec%0d_mispredictD", i), bus0.mispredictD, vecs[i].mis);
         chk($sformatf("vec%0d_isSaveReg31", i), bus0.isSaveReg31, vecs[i].s31);
         chk($sformatf("vec%0d_isSaveReg", i), bus0.isSaveReg, vecs[i].s);
         chk($sformatf("vec%0d_isJumpToReg", i), bus0.isJumpToReg, vecs[i].jr);
         chk($sformatf("vec%0d_isJumpToReg_en0", i), bus1.isJumpToReg, vecs[i].jr);
         chk($sformatf("vec%0d_isBranchD_en0", i), bus1.isBranchD, vecs[i].br);
      end
      chk("stalled_branchCnt", bus0.branchCnt, 32'd0);

      // First taken BEQ at 0x100, predicted not-taken
      step(32'h100, 32'h100, beq, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
      chk("beq_branchCnt", bus0.branchCnt, 32'd1);
      chk("beq_missCnt", bus0.missCnt, 32'd1);
      chk("beq_missCnt_en0", bus1.missCnt, 32'd1);
      nop(32'h100);
      chk("beq_predTakenF_next", bus0.predTakenF, 1'b1);
      chk("beq_predTakenF_en0", bus1.predTakenF, 1'b0);

      // Saturate at the top, then one not-taken step back down
      repeat (4) step(32'h100, 32'h100, beq, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
      step(32'h100, 32'h100, beq, 32'd9, 32'd8, 1'b1, 1'b0, 1'b1);
      nop(32'h100);
      chk("sat_then_nt_predTakenF", bus0.predTakenF, 1'b1);
      chk("sat_then_nt_model", m_tbl[idx_of(32'h100)], 32'd2);

      // Stalled BNE counted once on release
      b0 = m_bcnt;
      repeat (3) step(32'h0, 32'h304, bne, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
      chk("stall_hold_branchCnt", bus0.branchCnt, b0[31:0]);
      step(32'h0, 32'h304, bne, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
      chk("stall_release_branchCnt", bus0.branchCnt, b0[31:0] + 32'd1);

      // Reset asserted mid-cycle with an update pending aborts it
      drive(32'h400, 32'h400, beq, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_async_branchCnt", bus0.branchCnt, 32'd0);
      chk("rst_decode_isBranchD", bus0.isBranchD, 1'b1);
      chk("rst_decode_takenD", bus0.takenD, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("rst_abort_predTakenF", bus0.predTakenF, 1'b0);
      chk("rst_abort_missCnt", bus0.missCnt, 32'd0);
      nop(32'h100);
      chk("rst_clear_predTakenF_0x100", bus0.predTakenF, 1'b0);

      // Same-index update gives no bypass; 0x100 aliases onto 0x200's entry
      step(32'h200, 32'h200, beq, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0);
      chk("bypass_new_predTakenF", bus0.predTakenF, 1'b1);
      nop(32'h100);
      chk("alias_predTakenF", bus0.predTakenF, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         pcf  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
         pcd  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
         kind = $urandom_range(0, 9);
         case (kind)
            0: instr = enc(6'd4, 5'($urandom), 6'($urandom));
            1: instr = enc(6'd5, 5'($urandom), 6'($urandom));
            2: instr = enc(6'd6, 5'($urandom), 6'($urandom));
            3: instr = enc(6'd7, 5'($urandom), 6'($urandom));
            4, 5: instr = enc(6'd1, 5'($urandom), 6'($urandom));
            6: instr = enc(6'd3, 5'($urandom), 6'($urandom));
            7: instr = enc(6'd0, 5'($urandom), ($urandom_range(0, 1) == 0) ? 6'd8 : 6'd9);
            8: instr = enc(6'd2, 5'($urandom), 6'($urandom));
            default: instr = $urandom;
         endcase
         b = $urandom;
         case ($urandom_range(0, 4))
            0: a = 32'd0;
            1: a = b;
            2: a = 32'h80000000 | $urandom;
            3: a = 32'($urandom_range(1, 5));
            default: a = $urandom;
         endcase
         step(pcf, pcd, instr, a, b, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
              1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 64, meaning number of branch-history entries; power of 2, range 4..1024.
REQ-002 SHALL have parameter CNT_W, default 2, meaning saturating-counter width in bits; range 1..4.
REQ-003 SHALL have parameter PREDICT_EN, default 1, meaning 1 enables dynamic prediction and 0 forces static not-taken with the table frozen.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-005 SHALL have port pcF  in  32  fetch-stage PC.
REQ-006 SHALL have port predTakenF  out  1  prediction for the instruction at pcF.
REQ-007 SHALL have port validD  in  1  decode-stage instruction valid.
REQ-008 SHALL have port stallD  in  1  decode stall.
REQ-009 SHALL have port pcD  in  32  decode-stage PC.
REQ-010 SHALL have port instrD  in  32  decode-stage instruction.
REQ-011 SHALL have ports a, b  in  32 each  forwarded rs and rt values.
REQ-012 SHALL have port predTakenD  in  1  predTakenF as carried into decode by the pipeline.
REQ-013 SHALL have port isBranchD  out  1  conditional branch in decode.
REQ-014 SHALL have port takenD  out  1  resolved branch outcome.
REQ-015 SHALL have port mispredictD  out  1  flush/redirect request.
REQ-016 SHALL have ports isSaveReg31, isSaveReg, isJumpToReg  out  1 each  link and jump controls.
REQ-017 SHALL have ports branchCnt, missCnt  out  32 each  statistics.

Function
REQ-018 SHALL index the table with idx = pc[IDXW+1:2], where IDXW = log2(BHT_DEPTH).
REQ-019 SHALL drive predTakenF combinationally as the MSB of table[idx(pcF)] when PREDICT_EN=1, and as 0 when PREDICT_EN=0.
REQ-020 SHALL decode the conditional branches as BEQ op 000100, taken when a==b.
REQ-021 SHALL decode BNE op 000101, taken when a!=b.
REQ-022 SHALL decode BLEZ op 000110, taken when signed a<=0.
REQ-023 SHALL decode BGTZ op 000111, taken when signed a>0.
REQ-024 SHALL decode REGIMM op 000001 with rt[0]=0 as BLTZ/BLTZAL, taken when signed a<0.
REQ-025 SHALL decode REGIMM op 000001 with rt[0]=1 as BGEZ/BGEZAL, taken when signed a>=0.
REQ-026 SHALL assert isBranchD only for the branches in REQ-020..REQ-025 with validD=1, and SHALL force takenD=0 when isBranchD=0.
REQ-027 SHALL assert isSaveReg31 for JAL (op 000011), or for REGIMM with rt[4]=1, gated by validD.
REQ-028 SHALL assert isJumpToReg for op=000000 with funct 001000 (JR) or funct 001001 (JALR), gated by validD.
REQ-029 SHALL drive isSaveReg = isSaveReg31 | (op=000000 & funct=001001 & validD).
REQ-030 SHALL drive mispredictD = isBranchD & (takenD != predTakenD), combinationally.
REQ-031 SHALL produce no output for jumps (J, JAL, JR, JALR) on mispredictD; jumps are redirected by the pipeline, not by this block.
REQ-032 SHALL perform an update on the rising clk edge when isBranchD & ~stallD & PREDICT_EN=1.
REQ-033 SHALL, on such an update, increment table[idx(pcD)] when taken and decrement it when not taken, saturating at 0 and 2^CNT_W-1.
REQ-034 SHALL perform exactly one update per branch; a stalled branch held in decode for N cycles updates once, on the cycle stallD=0.
REQ-035 SHALL give no same-cycle bypass: when idx(pcF)==idx(pcD) during an update, predTakenF reflects the pre-update value, and the new value is visible the next cycle.
REQ-036 SHALL increment branchCnt on each update-qualified branch, independent of PREDICT_EN.
REQ-037 SHALL increment missCnt on each update-qualified branch with mispredictD=1, independent of PREDICT_EN.
REQ-038 SHALL saturate branchCnt and missCnt at 32'hFFFFFFFF with no wrap.
REQ-039 SHALL tolerate aliasing: different PCs mapping to the same idx share one entry, and no tag is kept.

Reset
REQ-040 SHALL, on rst=1 asynchronously, set every table entry to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2, 0 for CNT_W=1).
REQ-041 SHALL, on rst=1, clear branchCnt and missCnt to 0; predTakenF is therefore 0 for all PCs after reset.
REQ-042 SHALL abort any update in the cycle rst asserts mid-operation, leaving no partial write.
REQ-043 SHALL resume normal operation on the first clk edge after rst deasserts.
REQ-044 SHALL keep all combinational decode outputs independent of rst.

Verification
REQ-045 SHALL cover: reset, then BEQ at pcD=0x100 with a=b=5, predTakenD=0 -> takenD=1, mispredictD=1; next cycle predTakenF(pcF=0x100)=1 (counter 10); missCnt=1, branchCnt=1.
REQ-046 SHALL cover: four further taken updates at 0x100 -> counter saturates at 11; then one not-taken -> 10, and predTakenF stays 1.
REQ-047 SHALL cover: BGEZ (REGIMM, rt=00001) with a=0x80000000 -> takenD=0; BGEZAL (rt=10001) -> isSaveReg31=1, isSaveReg=1.
REQ-048 SHALL cover: BNE with a!=b held under stallD=1 for 3 cycles, then released -> branchCnt increments by 1 only.
REQ-049 SHALL cover: pcF=pcD=0x200 with a taken update in the same cycle -> predTakenF=0 that cycle and 1 the next.
REQ-050 SHALL cover: PREDICT_EN=0 -> predTakenF always 0, the table is never written, and missCnt counts every taken branch; JALR -> isJumpToReg=1, isSaveReg=1, isBranchD=0.
